// File: rtl/qnn_layer_sequencer.sv
// qnn_layer_sequencer: descriptor-driven multi-layer sequencer around an external dense engine.
// Optional cycle counter on perf_cycles, enabled by defining QNN_SEQ_PERF_EN.
module qnn_layer_sequencer #(
  parameter int DIM        = 16,
  parameter int ACC_W      = 32,
  parameter int ACT_W      = 8,
  parameter int DESC_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  logic [1:0]             desc_prec,
  input  logic [4:0]             desc_shift,
  input  logic                   desc_relu,
  input  logic                   desc_last,
  input  logic                   start,
  input  logic [DIM*ACT_W-1:0]   act_in,
  output logic                   eng_start,
  output logic [1:0]             eng_prec,
  output logic [DIM*ACT_W-1:0]   eng_act,
  input  logic                   eng_done,
  input  logic [DIM*ACC_W-1:0]   eng_acc,
  output logic [DIM*ACT_W-1:0]   result,
  output logic                   result_valid,
  output logic                   busy,
  output logic [7:0]             layer_cnt,
  output logic                   err,
  output logic [31:0]            perf_cycles
);
  localparam int PTR_W = $clog2(DESC_DEPTH);
  localparam int IDX_W = $clog2(DIM);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(32'd1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(32'd1);
  localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(32'd0);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DESC_DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'd1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM - 1);
  localparam logic signed [ACC_W-1:0] S_ZERO = ACC_W'(32'sd0);
  localparam logic signed [ACC_W-1:0] S_P1   = ACC_W'(32'sd1);
  localparam logic signed [ACC_W-1:0] S_M1   = ACC_W'(-32'sd1);
  localparam logic signed [ACC_W-1:0] I4_MAX = ACC_W'(32'sd7);
  localparam logic signed [ACC_W-1:0] I4_MIN = ACC_W'(-32'sd8);
  localparam logic signed [ACC_W-1:0] I8_MAX = ACC_W'(32'sd127);
  localparam logic signed [ACC_W-1:0] I8_MIN = ACC_W'(-32'sd128);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT = 3'd2, S_REQ = 3'd3, S_DONE = 3'd4
  } state_t;

  // Shift, optional ReLU, then clamp to the layer precision and sign-extend to ACT_W.
  function automatic logic [ACT_W-1:0] requant(input logic signed [ACC_W-1:0] acc,
                                               input logic [4:0] shift, input logic relu,
                                               input logic [1:0] prec);
    logic signed [ACC_W-1:0] v;
    logic signed [ACC_W-1:0] r;
    v = acc >>> shift;
    v = (relu && (v < S_ZERO)) ? S_ZERO : v;
    case (prec)
      2'b01:   r = (v > I4_MAX) ? I4_MAX : ((v < I4_MIN) ? I4_MIN : v);
      2'b10:   r = (v < S_ZERO) ? S_M1 : S_P1;
      default: r = (v > I8_MAX) ? I8_MAX : ((v < I8_MIN) ? I8_MIN : v);
    endcase
    return r[ACT_W-1:0];
  endfunction

  state_t state_r, state_s;
  logic [8:0]            fifo_mem_r [DESC_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]        count_r;
  logic                  full_s, empty_s, push_s, pop_s;
  logic [8:0]            head_s;
  logic                  start_ok_s, start_err_s, issue_s, capture_s, req_s, req_end_s;
  logic                  chain_err_s, done_s;
  logic                  busy_r, err_r, eng_start_r, result_valid_r;
  logic [1:0]            eng_prec_r;
  logic [4:0]            cur_shift_r;
  logic                  cur_relu_r, cur_last_r;
  logic [IDX_W-1:0]      idx_r;
  logic [7:0]            layer_cnt_r;
  logic [DIM*ACT_W-1:0]  act_buf_r, result_r;
  logic [DIM*ACC_W-1:0]  acc_r;

  assign full_s  = (count_r == CNT_FULL);
  assign empty_s = (count_r == CNT_ZERO);
  assign push_s  = desc_valid && !full_s;
  assign pop_s   = issue_s && !empty_s;
  assign head_s  = fifo_mem_r[rd_ptr_r];

  // Descriptor storage; only the write port needs a clock.
  always_ff @(posedge clk) begin
    if (push_s) fifo_mem_r[wr_ptr_r] <= {desc_prec, desc_shift, desc_relu, desc_last};
  end

  // FIFO pointers and occupancy; a full FIFO never accepts a push.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:  if (start && !empty_s) state_s = S_ISSUE; else state_s = S_IDLE;
      S_ISSUE: state_s = S_WAIT;
      S_WAIT:  if (eng_done) state_s = S_REQ; else state_s = S_WAIT;
      S_REQ: begin
        if (idx_r != IDX_LAST)  state_s = S_REQ;
        else if (cur_last_r)    state_s = S_DONE;
        else if (!empty_s)      state_s = S_ISSUE;
        else                    state_s = S_DONE;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Control strobes decoded from the current state.
  always_comb begin
    start_ok_s  = (state_r == S_IDLE) && start && !empty_s;
    start_err_s = (state_r == S_IDLE) && start && empty_s;
    issue_s     = (state_r == S_ISSUE);
    capture_s   = (state_r == S_WAIT) && eng_done;
    req_s       = (state_r == S_REQ);
    req_end_s   = req_s && (idx_r == IDX_LAST);
    chain_err_s = req_end_s && !cur_last_r && empty_s;
    done_s      = (state_r == S_DONE);
  end

  // Datapath: activation buffer, descriptor working copy, status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;  err_r <= 1'b0;  eng_start_r <= 1'b0;  result_valid_r <= 1'b0;
      eng_prec_r <= 2'b00;  cur_shift_r <= 5'd0;  cur_relu_r <= 1'b0;  cur_last_r <= 1'b0;
      idx_r <= '0;  layer_cnt_r <= 8'd0;
      act_buf_r <= '0;  result_r <= '0;  acc_r <= '0;
    end else begin
      eng_start_r    <= issue_s;
      result_valid_r <= done_s;
      if (start_ok_s) begin
        act_buf_r   <= act_in;
        layer_cnt_r <= 8'd0;
        busy_r      <= 1'b1;
      end else if (done_s) begin
        busy_r <= 1'b0;
      end
      if (start_ok_s) err_r <= 1'b0;
      else if (start_err_s || chain_err_s || (issue_s && head_s[8:7] == 2'b11)) err_r <= 1'b1;
      if (issue_s) begin
        // Reserved precision runs as int8.
        eng_prec_r  <= (head_s[8:7] == 2'b11) ? 2'b00 : head_s[8:7];
        cur_shift_r <= head_s[6:2];
        cur_relu_r  <= head_s[1];
        cur_last_r  <= head_s[0];
      end
      if (capture_s) acc_r <= eng_acc;
      if (req_s) begin
        act_buf_r[idx_r*ACT_W +: ACT_W] <=
          requant(acc_r[idx_r*ACC_W +: ACC_W], cur_shift_r, cur_relu_r, eng_prec_r);
        idx_r <= req_end_s ? '0 : idx_r + IDX_ONE;
        if (req_end_s && layer_cnt_r != 8'hFF) layer_cnt_r <= layer_cnt_r + 8'd1;
      end
      if (done_s) result_r <= act_buf_r;
    end
  end

`ifdef QNN_SEQ_PERF_EN
  logic [31:0] perf_r;
  // Busy-cycle counter, saturating.
  always_ff @(posedge clk) begin
    if (rst)                                  perf_r <= 32'd0;
    else if (start_ok_s)                      perf_r <= 32'd0;
    else if (busy_r && perf_r != 32'hFFFFFFFF) perf_r <= perf_r + 32'd1;
    else                                      perf_r <= perf_r;
  end
  assign perf_cycles = perf_r;
`else
  assign perf_cycles = 32'd0;
`endif

  assign desc_ready   = !full_s;
  assign eng_start    = eng_start_r;
  assign eng_prec     = eng_prec_r;
  assign eng_act      = act_buf_r;
  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign busy         = busy_r;
  assign layer_cnt    = layer_cnt_r;
  assign err          = err_r;
endmodule

// File: tb/tb_qnn_layer_sequencer.sv
// Directed bench for qnn_layer_sequencer with a behavioural dense-engine responder.
module tb_qnn_layer_sequencer;
  localparam int DIM = 16, ACC_W = 32, ACT_W = 8, DEPTH = 4;
  localparam int VW = DIM * ACT_W;
`ifdef QNN_SEQ_PERF_EN
  localparam logic [31:0] PERF_EXP = 32'd24;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic desc_valid = 1'b0, desc_ready;
  logic [1:0] desc_prec = 2'b00;
  logic [4:0] desc_shift = 5'd0;
  logic desc_relu = 1'b0, desc_last = 1'b0, start = 1'b0;
  logic [VW-1:0] act_in = '0;
  logic eng_start, eng_done = 1'b0;
  logic [1:0] eng_prec;
  logic [VW-1:0] eng_act, result;
  logic [DIM*ACC_W-1:0] eng_acc = '0, preset = '0, acc_v;
  logic result_valid, busy, err;
  logic [7:0] layer_cnt;
  logic [31:0] perf_cycles;

  int n_tests = 0, n_fail = 0;
  int n_starts = 0, rv_count = 0, eng_lat = 5, base = 0, rv0 = 0;
  logic echo_mode = 1'b0;
  logic [1:0] snap_prec [64];
  logic [VW-1:0] snap_act [64];
  logic [VW-1:0] exp_v;

  qnn_layer_sequencer #(.DIM(DIM), .ACC_W(ACC_W), .ACT_W(ACT_W), .DESC_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_prec(desc_prec), .desc_shift(desc_shift), .desc_relu(desc_relu),
    .desc_last(desc_last), .start(start), .act_in(act_in), .eng_start(eng_start),
    .eng_prec(eng_prec), .eng_act(eng_act), .eng_done(eng_done), .eng_acc(eng_acc),
    .result(result), .result_valid(result_valid), .busy(busy), .layer_cnt(layer_cnt),
    .err(err), .perf_cycles(perf_cycles));

  always #5 clk = ~clk;

  // Record every engine start and every result pulse.
  always @(posedge clk) begin
    if (eng_start) begin
      snap_prec[n_starts] = eng_prec;
      snap_act[n_starts]  = eng_act;
      n_starts++;
    end
    if (result_valid) rv_count++;
  end

  // Engine model: done arrives eng_lat cycles after the start pulse.
  always @(posedge clk) begin
    if (eng_start) begin
      repeat (eng_lat - 1) @(posedge clk);
      #1;
      for (int i = 0; i < DIM; i++)
        acc_v[i*ACC_W +: ACC_W] = echo_mode ?
          {{(ACC_W-ACT_W){eng_act[i*ACT_W+ACT_W-1]}}, eng_act[i*ACT_W +: ACT_W]} :
          preset[i*ACC_W +: ACC_W];
      eng_acc  = acc_v;
      eng_done = 1'b1;
      @(posedge clk); #1;
      eng_done = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] p, input logic [4:0] s, input logic r, input logic l);
    desc_valid = 1'b1; desc_prec = p; desc_shift = s; desc_relu = r; desc_last = l;
    tick();
    desc_valid = 1'b0;
  endtask

  task automatic do_start(input logic [ACT_W-1:0] a);
    act_in = {DIM{a}};
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_rv(input string tag, input int max);
    for (int i = 0; i < max && result_valid !== 1'b1; i++) tick();
    check(tag, VW'(result_valid), VW'(1'b1));
  endtask

  task automatic set_preset(input logic signed [ACC_W-1:0] v);
    for (int i = 0; i < DIM; i++) preset[i*ACC_W +: ACC_W] = v;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_busy", VW'(busy), VW'(1'b0));
    check("rst_ready", VW'(desc_ready), VW'(1'b1));
    check("rst_result", result, '0);
    check("rst_lcnt", VW'(layer_cnt), VW'(8'd0));
    check("rst_perf", VW'(perf_cycles), VW'(32'd0));

    // Single int8 layer with saturation both ways
    set_preset(32'sd300);
    preset[3*ACC_W +: ACC_W] = -32'sd300;
    push(2'b00, 5'd0, 1'b0, 1'b1);
    rv0 = rv_count;
    do_start(8'd1);
    check("t1_busy", VW'(busy), VW'(1'b1));
    wait_rv("t1_rv", 100);
    exp_v = {DIM{8'h7F}};
    exp_v[3*ACT_W +: ACT_W] = 8'h80;
    check("t1_result", result, exp_v);
    check("t1_lcnt", VW'(layer_cnt), VW'(8'd1));
    check("t1_err", VW'(err), VW'(1'b0));
    check("t1_busy_end", VW'(busy), VW'(1'b0));
    check("t1_perf", VW'(perf_cycles), VW'(PERF_EXP));
    tick();
    check("t1_rv_pulse", VW'(rv_count - rv0), VW'(1));
    check("t1_rv_low", VW'(result_valid), VW'(1'b0));

    // Three chained layers: int4+relu, binary, int8 shift 1
    echo_mode = 1'b1; eng_lat = 2; base = n_starts;
    push(2'b01, 5'd2, 1'b1, 1'b0);
    push(2'b10, 5'd0, 1'b0, 1'b0);
    push(2'b00, 5'd1, 1'b0, 1'b1);
    do_start(8'hEC);
    wait_rv("t2_rv", 300);
    check("t2_result", result, '0);
    check("t2_lcnt", VW'(layer_cnt), VW'(8'd3));
    check("t2_starts", VW'(n_starts - base), VW'(3));
    check("t2_act1", snap_act[base], {DIM{8'hEC}});
    check("t2_act2", snap_act[base+1], '0);
    check("t2_act3", snap_act[base+2], {DIM{8'h01}});
    check("t2_prec", VW'({snap_prec[base], snap_prec[base+1], snap_prec[base+2]}), VW'(6'b01_10_00));
    check("t2_err", VW'(err), VW'(1'b0));

    // Full FIFO, rejected fifth push, order preserved
    echo_mode = 1'b0; set_preset(32'sd5); base = n_starts;
    push(2'b00, 5'd0, 1'b0, 1'b0);
    push(2'b01, 5'd0, 1'b0, 1'b0);
    push(2'b10, 5'd0, 1'b0, 1'b0);
    push(2'b00, 5'd0, 1'b0, 1'b1);
    check("t3_full", VW'(desc_ready), VW'(1'b0));
    push(2'b01, 5'd3, 1'b1, 1'b1);
    check("t3_full_after5", VW'(desc_ready), VW'(1'b0));
    do_start(8'd0);
    tick();
    check("t3_ready_pop", VW'(desc_ready), VW'(1'b1));
    wait_rv("t3_rv", 400);
    check("t3_lcnt", VW'(layer_cnt), VW'(8'd4));
    check("t3_starts", VW'(n_starts - base), VW'(4));
    check("t3_order", VW'({snap_prec[base], snap_prec[base+1], snap_prec[base+2], snap_prec[base+3]}),
          VW'(8'b00_01_10_00));
    check("t3_result", result, {DIM{8'h05}});
    check("t3_err", VW'(err), VW'(1'b0));

    // Start on empty FIFO, then a non-last descriptor that runs dry
    base = n_starts;
    do_start(8'd0);
    check("t4_err_empty", VW'(err), VW'(1'b1));
    check("t4_busy_empty", VW'(busy), VW'(1'b0));
    repeat (4) tick();
    check("t4_no_start", VW'(n_starts - base), VW'(0));
    push(2'b00, 5'd0, 1'b0, 1'b0);
    rv0 = rv_count;
    do_start(8'd0);
    check("t4_err_clr", VW'(err), VW'(1'b0));
    wait_rv("t4_rv", 100);
    check("t4_err_dry", VW'(err), VW'(1'b1));
    tick();
    check("t4_rv_pulse", VW'(rv_count - rv0), VW'(1));

    // Reset while waiting on the engine; late done must be ignored
    eng_lat = 6;
    push(2'b00, 5'd0, 1'b0, 1'b1);
    do_start(8'd9);
    desc_valid = 1'b1; desc_last = 1'b1;
    tick();
    desc_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", VW'(busy), VW'(1'b0));
    check("t5_ready", VW'(desc_ready), VW'(1'b1));
    check("t5_eng_start", VW'(eng_start), VW'(1'b0));
    rv0 = rv_count;
    repeat (8) tick();
    check("t5_busy_late", VW'(busy), VW'(1'b0));
    check("t5_no_rv", VW'(rv_count - rv0), VW'(0));
    check("t5_lcnt", VW'(layer_cnt), VW'(8'd0));
    do_start(8'd0);
    check("t5_flushed_err", VW'(err), VW'(1'b1));
    check("t5_flushed_busy", VW'(busy), VW'(1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
